// File: rtl/onn_pkg.sv
// Shared ONN readout definitions: default phase width, step length and the
// readout FSM state encoding.
package onn_pkg;

  localparam int unsigned PHW_DEF      = 4;
  localparam int unsigned STEP_CYC_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/osc_phase_capture.sv
// Per-neuron phase capture: registers the oscillation, detects its first rising
// edge in each reference period and compares the captured step to the last period.
module osc_phase_capture
  import onn_pkg::*;
#(
  parameter int unsigned PHW = PHW_DEF
) (
  input  logic           sclk,
  input  logic           re,
  input  logic           osc_i,
  input  logic [PHW-1:0] step,
  input  logic           period_tick,
  input  logic           clr,
  output logic           match,
  output logic [PHW-1:0] cap
);

  logic           osc_r_q, osc_r_d;
  logic           osc_p_q, osc_p_d;
  logic           seen_q, seen_d;
  logic           prev_valid_q, prev_valid_d;
  logic [PHW-1:0] cap_q, cap_d;
  logic [PHW-1:0] prev_cap_q, prev_cap_d;
  logic           osc_edge;

  always_comb begin
    osc_r_d      = osc_i;
    osc_p_d      = osc_r_q;
    osc_edge     = osc_r_q & ~osc_p_q;
    cap_d        = cap_q;
    seen_d       = seen_q;
    prev_cap_d   = prev_cap_q;
    prev_valid_d = prev_valid_q;

    if (clr) begin
      cap_d        = '0;
      seen_d       = 1'b0;
      prev_cap_d   = '0;
      prev_valid_d = 1'b0;
    end else if (period_tick) begin
      prev_cap_d   = cap_q;
      prev_valid_d = seen_q;
      seen_d       = 1'b0;
    end

    // An edge on the period boundary opens the new period; while cleared and
    // off the boundary, edges are ignored.
    if (osc_edge && !seen_d && (period_tick || !clr)) begin
      cap_d  = step;
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      osc_r_q      <= 1'b0;
      osc_p_q      <= 1'b0;
      seen_q       <= 1'b0;
      prev_valid_q <= 1'b0;
      cap_q        <= '0;
      prev_cap_q   <= '0;
    end else begin
      osc_r_q      <= osc_r_d;
      osc_p_q      <= osc_p_d;
      seen_q       <= seen_d;
      prev_valid_q <= prev_valid_d;
      cap_q        <= cap_d;
      prev_cap_q   <= prev_cap_d;
    end
  end

  assign match = seen_q & prev_valid_q & (cap_q == prev_cap_q);
  assign cap   = cap_q;

endmodule

// File: rtl/onn_phase_reader.sv
// ONN phase readout: measures each neuron's phase against the reference
// oscillation and latches the vector once it has been stable for long enough.
module onn_phase_reader
  import onn_pkg::*;
#(
  parameter int unsigned N              = 15,
  parameter int unsigned PHW            = PHW_DEF,
  parameter int unsigned STEP_CYC       = STEP_CYC_DEF,
  parameter int unsigned STABLE_PERIODS = 3,
  parameter int unsigned MAX_PERIODS    = 255
) (
  input  logic             sclk,
  input  logic             re,
  input  logic             start,
  input  logic             ref_osc,
  input  logic [N-1:0]     osc,
  output logic [N*PHW-1:0] phases_out,
  output logic             done,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned PSW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int unsigned SCW = $clog2(STABLE_PERIODS + 1);
  localparam int unsigned PCW = 8;

  state_e           state_q, state_d;
  logic             ref_r_q, ref_r_d;
  logic             ref_p_q, ref_p_d;
  logic [PSW-1:0]   presc_q, presc_d;
  logic [PHW-1:0]   step_q, step_d;
  logic [SCW-1:0]   stable_q, stable_d;
  logic [PCW-1:0]   period_q, period_d;
  logic             timeout_q, timeout_d;
  logic [N*PHW-1:0] phases_q, phases_d;

  logic             ref_edge;
  logic             in_meas;
  logic             count_en;
  logic             period_tick;
  logic             clr;
  logic [PSW-1:0]   presc_eff;
  logic [PHW-1:0]   step_eff;
  logic [N-1:0]     match;
  logic [N*PHW-1:0] cap_flat;

  always_comb begin
    ref_r_d     = ref_osc;
    ref_p_d     = ref_r_q;
    ref_edge    = ref_r_q & ~ref_p_q;
    in_meas     = (state_q == ST_MEASURE);
    count_en    = in_meas || ((state_q == ST_ALIGN) && ref_edge);
    period_tick = ref_edge && ((state_q == ST_ALIGN) || in_meas);
    clr         = !in_meas;

    // The ref-edge cycle itself reads as step 0, so an edge k cycles later maps to floor(k/STEP_CYC).
    presc_eff = (in_meas && !ref_edge) ? presc_q : '0;
    step_eff  = (in_meas && !ref_edge) ? step_q  : '0;

    presc_d = '0;
    step_d  = '0;
    if (count_en) begin
      if (presc_eff == PSW'(STEP_CYC - 1)) begin
        presc_d = '0;
        step_d  = step_eff + PHW'(1);
      end else begin
        presc_d = presc_eff + PSW'(1);
        step_d  = step_eff;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_nrn
    osc_phase_capture #(
      .PHW (PHW)
    ) u_cap (
      .sclk        (sclk),
      .re          (re),
      .osc_i       (osc[gi]),
      .step        (step_eff),
      .period_tick (period_tick),
      .clr         (clr),
      .match       (match[gi]),
      .cap         (cap_flat[gi*PHW +: PHW])
    );
  end

  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    period_d  = period_q;
    timeout_d = timeout_q;
    phases_d  = phases_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_ALIGN;
          timeout_d = 1'b0;
        end
      end
      ST_ALIGN: begin
        stable_d = '0;
        period_d = '0;
        if (ref_edge) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (ref_edge) begin
          period_d = period_q + PCW'(1);
          stable_d = (&match) ? stable_q + SCW'(1) : '0;
          // cap_flat is the period just closed, i.e. what becomes prev_cap.
          if (stable_d == SCW'(STABLE_PERIODS)) begin
            phases_d  = cap_flat;
            timeout_d = 1'b0;
            state_d   = ST_DONE;
          end else if (period_d == PCW'(MAX_PERIODS)) begin
            phases_d  = cap_flat;
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      state_q   <= ST_IDLE;
      ref_r_q   <= 1'b0;
      ref_p_q   <= 1'b0;
      presc_q   <= '0;
      step_q    <= '0;
      stable_q  <= '0;
      period_q  <= '0;
      timeout_q <= 1'b0;
      phases_q  <= '0;
    end else begin
      state_q   <= state_d;
      ref_r_q   <= ref_r_d;
      ref_p_q   <= ref_p_d;
      presc_q   <= presc_d;
      step_q    <= step_d;
      stable_q  <= stable_d;
      period_q  <= period_d;
      timeout_q <= timeout_d;
      phases_q  <= phases_d;
    end
  end

  assign phases_out = phases_q;
  assign timeout    = timeout_q;
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q == ST_ALIGN) || (state_q == ST_MEASURE);

endmodule
